mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side end of the request-unit protocol. Takes imemREN / dmemREN / dmemWEN
//  from the request unit, arbitrates one access at a time onto the single RAM port,
//  and returns single-cycle ihit / dhit pulses with registered load data.
//  Sits between the datapath's request unit and the RAM wrapper.
// PARAMETERS
//  TIMEOUT  64  max cycles waiting for ramready before abort; counter is $clog2(TIMEOUT+1) bits
// PORTS
//  CLK        in   1   clock, rising edge
//  nRST       in   1   reset, synchronous, active-low
//  imemREN    in   1   instruction fetch request (level, held until ihit)
//  imemaddr   in   32  fetch word address
//  dmemREN    in   1   data read request (level, held until dhit)
//  dmemWEN    in   1   data write request (level, held until dhit)
//  dmemaddr   in   32  data address
//  dmemstore  in   32  write data
//  ihit       out  1   one-cycle pulse: fetch complete, imemload valid
//  dhit       out  1   one-cycle pulse: data access complete, dmemload valid on reads
//  imemload   out  32  registered fetch data, held until next ihit
//  dmemload   out  32  registered read data, held until next read dhit
//  ramREN     out  1   RAM read strobe
//  ramWEN     out  1   RAM write strobe
//  ramaddr    out  32  RAM address (latched request address)
//  ramstore   out  32  RAM write data (latched)
//  ramload    in   32  RAM read data, valid with ramready
//  ramready   in   1   RAM access complete this cycle
//  memerr     out  1   one-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset (nRST=0 at edge): state IDLE, every output 0, loads 0, counter 0, last_d=0.
//  States: IDLE, DACC, IACC, DONE.
//  IDLE: data pending (dmemREN|dmemWEN) and not (imemREN & last_d) -> DACC;
//   else imemREN -> IACC. Latch addr/store/we on the transition edge.
//   Fairness: both pending and previous grant was data -> instruction served first.
//  dmemREN & dmemWEN together: write performed, read ignored.
//  DACC/IACC: ramREN or ramWEN high (never both), ramaddr/ramstore from latches.
//   ramready=1 -> DONE; capture ramload into dmemload/imemload (reads only).
//   Requester drops its REN/WEN before ramready -> abort to IDLE next edge, no hit.
//   Counter reaches TIMEOUT with no ramready -> IDLE, memerr pulse, no hit.
//  DONE: exactly one of ihit/dhit high for one cycle, RAM strobes low;
//   new requests not sampled this cycle; next state IDLE; last_d updated.
//  Latency: request seen at edge t -> RAM strobe cycle t+1 -> ramready at t+1+k
//   -> hit in cycle t+2+k. Minimum request-to-hit is 2 cycles (k=0).
//  Hits and memerr are registered outputs, glitch-free. Counter cleared on every
//   state entry; saturates, never wraps.
//  Reset mid-access: abort immediately, no hit, RAM strobes low next cycle.
// STRUCTURE
//  cpu_types_pkg: word_t (32-bit), memstate_t enum {IDLE, DACC, IACC, DONE}.
//  Single module; timeout counter inline (no sub-module).
// TESTING
//  Reset: hold nRST=0 with imemREN=1 -> all outputs 0, no ramREN.
//  Fetch, ramready after 3 cycles, ramload=32'h2002_0001 -> ihit 1 cycle, imemload=32'h2002_0001.
//  imemREN & dmemWEN together, last_d=0 -> write first (ramWEN, addr/data latched), dhit, then fetch, ihit.
//  Back-to-back: 2nd data read pending with fetch -> fetch granted before 2nd read.
//  dmemREN dropped during DACC -> IDLE next edge, no dhit, dmemload unchanged.
//  ramready never asserted -> memerr pulse at cycle TIMEOUT (64), no hit, IDLE.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word type and memory-responder state encoding
// Contents:
//   word_t     - 32-bit data/address word
//   memstate_t - responder FSM states IDLE, DACC, IACC, DONE
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {IDLE, DACC, IACC, DONE} memstate_t;
endpackage

// File: rtl/mem_responder.sv
// mem_responder: arbitrates fetch/data requests onto one RAM port and returns registered hits
// Ports:
//   CLK, nRST                      clock (rising edge), synchronous active-low reset
//   imemREN, imemaddr              fetch request level and word address
//   dmemREN, dmemWEN               data read/write request levels (write wins if both)
//   dmemaddr, dmemstore            data address and write data
//   ihit, dhit                     one-cycle completion pulses
//   imemload, dmemload             registered load data, held until the next read hit
//   ramREN, ramWEN                 RAM strobes, at most one high
//   ramaddr, ramstore              latched request address and write data
//   ramload, ramready              RAM read data and completion
//   memerr                         one-cycle pulse when an access times out
module mem_responder
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic  CLK,
   input  logic  nRST,
   input  logic  imemREN,
   input  word_t imemaddr,
   input  logic  dmemREN,
   input  logic  dmemWEN,
   input  word_t dmemaddr,
   input  word_t dmemstore,
   output logic  ihit,
   output logic  dhit,
   output word_t imemload,
   output word_t dmemload,
   output logic  ramREN,
   output logic  ramWEN,
   output word_t ramaddr,
   output word_t ramstore,
   input  word_t ramload,
   input  logic  ramready,
   output logic  memerr
);
   localparam int CW = $clog2(TIMEOUT + 1);
   memstate_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic lastd_q, lastd_d, isd_q, isd_d, we_q, we_d;
   logic ihit_q, ihit_d, dhit_q, dhit_d, err_q, err_d;
   word_t addr_q, addr_d, store_q, store_d, iload_q, iload_d, dload_q, dload_d;
   logic dreq, live;
   always_comb begin
      dreq = dmemREN | dmemWEN;
      // the access survives only while the requester that owns it keeps asking
      live = (state_q == IACC) ? imemREN : (we_q ? dmemWEN : dmemREN);
      cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
      state_d = state_q;
      lastd_d = lastd_q;
      isd_d = isd_q;
      we_d = we_q;
      addr_d = addr_q;
      store_d = store_q;
      iload_d = iload_q;
      dload_d = dload_q;
      ihit_d = 1'b0;
      dhit_d = 1'b0;
      err_d = 1'b0;
      case (state_q)
         IDLE: begin
            // data wins unless a fetch is waiting and data had the last grant
            if (dreq && !(imemREN && lastd_q)) begin
               state_d = DACC;
               isd_d = 1'b1;
               we_d = dmemWEN;
               addr_d = dmemaddr;
               store_d = dmemstore;
            end else if (imemREN) begin
               state_d = IACC;
               isd_d = 1'b0;
               we_d = 1'b0;
               addr_d = imemaddr;
            end
         end
         DACC, IACC: begin
            if (!live) begin
               state_d = IDLE;
            end else if (ramready) begin
               state_d = DONE;
               ihit_d = !isd_q;
               dhit_d = isd_q;
               iload_d = (state_q == IACC) ? ramload : iload_q;
               dload_d = (state_q == DACC && !we_q) ? ramload : dload_q;
            end else if (cnt_inc == CW'(TIMEOUT)) begin
               state_d = IDLE;
               err_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            lastd_d = isd_q;
         end
      endcase
      cnt_d = (state_d != state_q) ? '0 : cnt_inc;
   end
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= IDLE;
         cnt_q <= '0;
         lastd_q <= 1'b0;
         isd_q <= 1'b0;
         we_q <= 1'b0;
         addr_q <= '0;
         store_q <= '0;
         iload_q <= '0;
         dload_q <= '0;
         ihit_q <= 1'b0;
         dhit_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         lastd_q <= lastd_d;
         isd_q <= isd_d;
         we_q <= we_d;
         addr_q <= addr_d;
         store_q <= store_d;
         iload_q <= iload_d;
         dload_q <= dload_d;
         ihit_q <= ihit_d;
         dhit_q <= dhit_d;
         err_q <= err_d;
      end
   end
   assign ramREN = (state_q == IACC) || (state_q == DACC && !we_q);
   assign ramWEN = (state_q == DACC) && we_q;
   assign ramaddr = addr_q;
   assign ramstore = store_q;
   assign ihit = ihit_q;
   assign dhit = dhit_q;
   assign memerr = err_q;
   assign imemload = iload_q;
   assign dmemload = dload_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: vector table, directed corner sequences and randomized model check of mem_responder
// Ports: none (drives every mem_responder port, generates CLK)
module tb_mem_responder;
   import cpu_types_pkg::*;
   logic CLK, nRST, imemREN, dmemREN, dmemWEN, ramready;
   word_t imemaddr, dmemaddr, dmemstore, ramload;
   logic ihit, dhit, ramREN, ramWEN, memerr;
   word_t imemload, dmemload, ramaddr, ramstore;
   int n_cmp, n_err;

   mem_responder #(.TIMEOUT(64)) dut (
      .CLK(CLK), .nRST(nRST),
      .imemREN(imemREN), .imemaddr(imemaddr),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramready(ramready), .memerr(memerr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      int    kind;
      word_t a;
      word_t d;
      int    k;
      logic  ih;
      logic  dh;
      int    lat;
      word_t ld;
      logic  sw;
   } vec_t;
   vec_t tbl[6];

   logic o_ih, o_dh, o_sw;
   int o_lat;
   word_t o_ld, o_sa, o_ss;
   word_t ram_mem[16], ref_mem[16];
   logic gd, in_acc, lastd_m;
   int dly, nh;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic clear_in();
      imemREN = 0; dmemREN = 0; dmemWEN = 0; ramready = 0;
      imemaddr = 0; dmemaddr = 0; dmemstore = 0; ramload = 0;
   endtask

   task automatic do_reset();
      clear_in();
      nRST = 0;
      repeat (2) step();
      nRST = 1;
   endtask

   // kind: 0 fetch, 1 read, 2 write, 3 read+write; RAM answers after k strobe cycles
   task automatic run_txn(input int kind, input word_t a, input word_t d, input int k);
      int strobes;
      imemREN = (kind == 0);
      dmemREN = (kind == 1 || kind == 3);
      dmemWEN = (kind >= 2);
      imemaddr = a; dmemaddr = a; dmemstore = d;
      o_ih = 0; o_dh = 0; o_sw = 0; o_lat = -1; o_ld = 0; o_sa = 0; o_ss = 0;
      strobes = 0;
      for (int c = 1; c <= 200; c++) begin
         step();
         ramready = 0;
         if (ihit || dhit) begin
            o_ih = ihit; o_dh = dhit; o_lat = c;
            o_ld = ihit ? imemload : dmemload;
            break;
         end
         if (ramREN || ramWEN) begin
            o_sw = ramWEN; o_sa = ramaddr; o_ss = ramstore;
            if (strobes == k) begin
               ramready = 1;
               ramload = ramWEN ? ~d : d;
            end
            strobes++;
         end
      end
      clear_in();
      step();
   endtask

   task automatic new_reqs();
      int r;
      if (!imemREN && ($urandom % 2 == 1)) begin
         imemREN = 1;
         imemaddr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!dmemREN && !dmemWEN && ($urandom % 2 == 1)) begin
         r = $urandom_range(0, 2);
         dmemREN = (r != 1);
         dmemWEN = (r != 0);
         dmemaddr = $urandom() & 32'hFFFF_FFFC;
         dmemstore = $urandom();
      end
   endtask

   initial begin
      logic got_err, hit_seen;
      int strobes;
      n_cmp = 0; n_err = 0;
      tbl[0] = '{0, 32'h0000_0100, 32'h2002_0001, 3, 1'b1, 1'b0, 5, 32'h2002_0001, 1'b0};
      tbl[1] = '{1, 32'h0000_0200, 32'hA5A5_0001, 0, 1'b0, 1'b1, 2, 32'hA5A5_0001, 1'b0};
      tbl[2] = '{2, 32'h0000_0300, 32'h1234_5678, 1, 1'b0, 1'b1, 3, 32'hA5A5_0001, 1'b1};
      tbl[3] = '{3, 32'h0000_0304, 32'hCAFE_F00D, 2, 1'b0, 1'b1, 4, 32'hA5A5_0001, 1'b1};
      tbl[4] = '{1, 32'h0000_0400, 32'h0BAD_CAFE, 5, 1'b0, 1'b1, 7, 32'h0BAD_CAFE, 1'b0};
      tbl[5] = '{0, 32'h0000_0104, 32'hFFFF_FFFF, 0, 1'b1, 1'b0, 2, 32'hFFFF_FFFF, 1'b0};

      // reset held with a fetch pending
      clear_in();
      nRST = 0;
      imemREN = 1; imemaddr = 32'h0000_0ABC;
      repeat (3) begin
         step();
         chk("rst_ramREN", ramREN, 0);
      end
      chk("rst_ramWEN", ramWEN, 0);
      chk("rst_ihit", ihit, 0);
      chk("rst_dhit", dhit, 0);
      chk("rst_memerr", memerr, 0);
      chk("rst_imemload", imemload, 0);
      chk("rst_dmemload", dmemload, 0);
      chk("rst_ramaddr", ramaddr, 0);
      chk("rst_ramstore", ramstore, 0);
      clear_in();
      nRST = 1;
      step();

      foreach (tbl[i]) begin
         run_txn(tbl[i].kind, tbl[i].a, tbl[i].d, tbl[i].k);
         chk($sformatf("v%0d_ihit", i), o_ih, tbl[i].ih);
         chk($sformatf("v%0d_dhit", i), o_dh, tbl[i].dh);
         chk($sformatf("v%0d_lat", i), o_lat, tbl[i].lat);
         chk($sformatf("v%0d_load", i), o_ld, tbl[i].ld);
         chk($sformatf("v%0d_ramWEN", i), o_sw, tbl[i].sw);
         chk($sformatf("v%0d_ramaddr", i), o_sa, tbl[i].a);
         if (tbl[i].sw) chk($sformatf("v%0d_ramstore", i), o_ss, tbl[i].d);
      end

      // fetch and write together with last grant = fetch: write first, then fetch
      do_reset();
      imemREN = 1; imemaddr = 32'h0000_0500;
      dmemWEN = 1; dmemaddr = 32'h0000_0600; dmemstore = 32'h0000_7777;
      step();
      chk("a_ramWEN", ramWEN, 1);
      chk("a_ramREN", ramREN, 0);
      chk("a_ramaddr", ramaddr, 32'h0000_0600);
      chk("a_ramstore", ramstore, 32'h0000_7777);
      ramready = 1;
      step();
      chk("a_dhit", dhit, 1);
      chk("a_ihit0", ihit, 0);
      chk("a_strobe_done", ramWEN | ramREN, 0);
      dmemWEN = 0; ramready = 0;
      step();
      step();
      chk("a_fetch_ramREN", ramREN, 1);
      chk("a_fetch_addr", ramaddr, 32'h0000_0500);
      ramready = 1; ramload = 32'h0000_5555;
      step();
      chk("a_ihit", ihit, 1);
      chk("a_imemload", imemload, 32'h0000_5555);
      clear_in();
      step();

      // second data read waiting alongside a fetch after a data grant: fetch goes first
      dmemREN = 1; dmemaddr = 32'h0000_0700;
      step();
      chk("b_ramREN", ramREN, 1);
      ramready = 1; ramload = 32'h7000_0700;
      step();
      chk("b_dhit1", dhit, 1);
      chk("b_dload1", dmemload, 32'h7000_0700);
      ramready = 0;
      dmemaddr = 32'h0000_0704;
      imemREN = 1; imemaddr = 32'h0000_0108;
      step();
      chk("b_no_hit_idle", ihit | dhit, 0);
      step();
      chk("b_fetch_first", ramaddr, 32'h0000_0108);
      chk("b_fetch_ramREN", ramREN, 1);
      ramready = 1; ramload = 32'h1080_0000;
      step();
      chk("b_ihit", ihit, 1);
      chk("b_dhit0", dhit, 0);
      chk("b_imemload", imemload, 32'h1080_0000);
      ramready = 0; imemREN = 0;
      step();
      step();
      chk("b_read2_addr", ramaddr, 32'h0000_0704);
      ramready = 1; ramload = 32'h7040_0000;
      step();
      chk("b_dhit2", dhit, 1);
      chk("b_dload2", dmemload, 32'h7040_0000);
      clear_in();
      step();

      // requester withdraws mid-access
      dmemREN = 1; dmemaddr = 32'h0000_0800;
      step();
      chk("c_ramREN1", ramREN, 1);
      step();
      chk("c_ramREN2", ramREN, 1);
      dmemREN = 0; ramload = 32'hDEAD_DEAD;
      step();
      chk("c_abort_ramREN", ramREN, 0);
      chk("c_abort_dhit", dhit, 0);
      step();
      chk("c_after_dhit", dhit, 0);
      chk("c_dmemload_kept", dmemload, 32'h7040_0000);

      // RAM never answers: memerr after 64 strobe cycles
      imemREN = 1; imemaddr = 32'h0000_0900;
      got_err = 0; hit_seen = 0; strobes = 0;
      for (int c = 0; c < 200; c++) begin
         step();
         if (ihit || dhit) hit_seen = 1;
         if (memerr) begin
            got_err = 1;
            break;
         end
         if (ramREN) strobes++;
      end
      chk("d_memerr", got_err, 1);
      chk("d_strobe_cycles", strobes, 64);
      chk("d_no_hit", hit_seen, 0);
      chk("d_idle_ramREN", ramREN, 0);
      imemREN = 0;
      step();
      chk("d_memerr_pulse", memerr, 0);

      // reset in the middle of an access
      imemREN = 1; imemaddr = 32'h0000_0A00;
      step();
      chk("e_ramREN", ramREN, 1);
      nRST = 0; ramready = 1; ramload = 32'h1111_1111;
      step();
      chk("e_ramREN_off", ramREN, 0);
      chk("e_no_ihit", ihit, 0);
      chk("e_imemload", imemload, 0);
      nRST = 1; ramready = 0; imemREN = 0;
      step();
      chk("e_no_ihit2", ihit, 0);

      // randomized traffic against a transaction-level model
      do_reset();
      for (int i = 0; i < 16; i++) begin
         ram_mem[i] = $urandom();
         ref_mem[i] = ram_mem[i];
      end
      lastd_m = 0; in_acc = 0; nh = 0; dly = 0; gd = 0;
      new_reqs();
      for (int c = 0; c < 3000; c++) begin
         step();
         ramready = 0;
         if (ihit || dhit) begin
            chk("rnd_hit_is_data", dhit, gd);
            chk("rnd_one_hit", ihit ^ dhit, 1);
            if (gd) begin
               if (dmemWEN) ref_mem[dmemaddr[5:2]] = dmemstore;
               else chk("rnd_dmemload", dmemload, ref_mem[dmemaddr[5:2]]);
               dmemREN = 0; dmemWEN = 0;
            end else begin
               chk("rnd_imemload", imemload, ref_mem[imemaddr[5:2]]);
               imemREN = 0;
            end
            lastd_m = gd; in_acc = 0; nh++;
            new_reqs();
         end else if (ramREN || ramWEN) begin
            if (!in_acc) begin
               in_acc = 1;
               gd = (dmemREN || dmemWEN) && !(imemREN && lastd_m);
               chk("rnd_grant_addr", ramaddr, gd ? dmemaddr : imemaddr);
               chk("rnd_grant_wen", ramWEN, gd && dmemWEN);
               chk("rnd_grant_ren", ramREN, !(gd && dmemWEN));
               if (gd && dmemWEN) chk("rnd_ramstore", ramstore, dmemstore);
               dly = $urandom_range(0, 3);
            end
            if (dly == 0) begin
               ramready = 1;
               ramload = ram_mem[ramaddr[5:2]];
               if (ramWEN) ram_mem[ramaddr[5:2]] = ramstore;
            end else dly--;
         end else if (!in_acc && !imemREN && !dmemREN && !dmemWEN) begin
            new_reqs();
         end
      end
      chk("rnd_hit_count_ok", nh >= 200, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
